// File: rtl/uart_loader.sv
// Serial boot loader: receives A5-framed address/count/data over 8N1 UART, issues
// 32-bit bus writes, then answers with a single 8'h5A ack byte.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// WAIT_HDR | discard bytes until header 8'hA5
// ADDR     | collect 4-byte little-endian start address
// COUNT    | collect 2-byte little-endian word count
// DATA     | assemble words, write every 4th byte
// ACK      | transmit 8'h5A, pulse done at end of stop bit
module uart_loader #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic        WE,
    output logic [3:0]  BE,
    output logic [31:0] Addr,
    output logic [31:0] Dout,
    output logic        done,
    output logic        frame_err
);

    localparam logic [15:0] FULL_TC  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_TC  = 16'((BAUD_DIV / 2) - 1);
    localparam logic [7:0]  HDR_BYTE = 8'hA5;
    localparam logic [7:0]  ACK_BYTE = 8'h5A;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {WAIT_HDR, ADDR, COUNT, DATA, ACK} state_t;

    rx_state_t   rx_state;
    logic        rx_meta, rx_sync, rx_prev;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_sr;
    logic        rx_valid;
    logic [7:0]  rx_byte;

    state_t      state;
    logic [1:0]  byte_idx;
    logic [23:0] sr;
    logic [31:0] addr;
    logic [15:0] remaining;
    logic [15:0] tx_cnt;
    logic [3:0]  tx_idx;

    // Receiver: each timer reload targets the middle of the next bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            rx_state  <= RX_IDLE;
            rx_cnt    <= 16'd0;
            rx_bit    <= 3'd0;
            rx_sr     <= 8'd0;
            rx_valid  <= 1'b0;
            rx_byte   <= 8'd0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= uart_rxd;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_cnt   <= HALF_TC;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == 16'd0) begin
                        if (rx_sync) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_cnt   <= FULL_TC;
                            rx_bit   <= 3'd0;
                            rx_state <= RX_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_sr  <= {rx_sync, rx_sr[7:1]};
                        rx_cnt <= FULL_TC;
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == 16'd0) begin
                        if (rx_sync) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= rx_sr;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WAIT_HDR;
            byte_idx  <= 2'd0;
            sr        <= 24'd0;
            addr      <= 32'd0;
            remaining <= 16'd0;
            tx_cnt    <= 16'd0;
            tx_idx    <= 4'd0;
            uart_txd  <= 1'b1;
            WE        <= 1'b0;
            BE        <= 4'h0;
            Addr      <= 32'd0;
            Dout      <= 32'd0;
            done      <= 1'b0;
        end else begin
            WE   <= 1'b0;
            BE   <= 4'h0;
            done <= 1'b0;
            // The ack transmission is never cut short; RX activity is ignored during it.
            if (frame_err && state != ACK) begin
                state    <= WAIT_HDR;
                byte_idx <= 2'd0;
            end else begin
                case (state)
                    WAIT_HDR: begin
                        if (rx_valid && rx_byte == HDR_BYTE) begin
                            state    <= ADDR;
                            byte_idx <= 2'd0;
                        end
                    end
                    ADDR: begin
                        if (rx_valid) begin
                            sr       <= {rx_byte, sr[23:8]};
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                addr     <= {rx_byte, sr[23:2], 2'b00};
                                byte_idx <= 2'd0;
                                state    <= COUNT;
                            end
                        end
                    end
                    COUNT: begin
                        if (rx_valid) begin
                            sr       <= {rx_byte, sr[23:8]};
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd1) begin
                                byte_idx  <= 2'd0;
                                remaining <= {rx_byte, sr[23:16]};
                                if ({rx_byte, sr[23:16]} == 16'd0) begin
                                    state    <= ACK;
                                    uart_txd <= 1'b0;
                                    tx_cnt   <= FULL_TC;
                                    tx_idx   <= 4'd0;
                                end else begin
                                    state <= DATA;
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (rx_valid) begin
                            sr       <= {rx_byte, sr[23:8]};
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                WE        <= 1'b1;
                                BE        <= 4'hF;
                                Addr      <= addr;
                                Dout      <= {rx_byte, sr};
                                addr      <= addr + 32'd4;
                                remaining <= remaining - 16'd1;
                                if (remaining == 16'd1) begin
                                    state    <= ACK;
                                    uart_txd <= 1'b0;
                                    tx_cnt   <= FULL_TC;
                                    tx_idx   <= 4'd0;
                                end
                            end
                        end
                    end
                    ACK: begin
                        // tx_idx: 0 = start bit, 1..8 = data bits, 9 = stop bit
                        if (tx_cnt == 16'd0) begin
                            if (tx_idx == 4'd9) begin
                                done  <= 1'b1;
                                state <= WAIT_HDR;
                            end else begin
                                uart_txd <= (tx_idx < 4'd8) ? ACK_BYTE[tx_idx[2:0]] : 1'b1;
                                tx_idx   <= tx_idx + 4'd1;
                                tx_cnt   <= FULL_TC;
                            end
                        end else begin
                            tx_cnt <= tx_cnt - 16'd1;
                        end
                    end
                    default: state <= WAIT_HDR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader at BAUD_DIV=16: frame table plus hand sequences for
// framing error, start glitch and mid-frame reset.
module tb_uart_loader;

    localparam int B = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        uart_rxd;
    logic        uart_txd;
    logic        WE;
    logic [3:0]  BE;
    logic [31:0] Addr;
    logic [31:0] Dout;
    logic        done;
    logic        frame_err;

    uart_loader #(.BAUD_DIV(B)) dut (
        .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
        .WE(WE), .BE(BE), .Addr(Addr), .Dout(Dout), .done(done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
    typedef struct {logic [7:0] b; logic stop; int len;} ack_t;
    typedef struct {
        logic [31:0] addr;
        int          n;
        logic [31:0] w0, w1;
        logic [31:0] ea0, ea1;
        bit          junk;
    } vec_t;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   done_cnt = 0, ferr_cnt = 0, be_bad = 0;
    wr_t  exp_q[$];
    wr_t  obs_q[$];
    int   obs_rd = 0;
    ack_t ack_q[$];
    int   ack_rd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (frame_err) ferr_cnt++;
        if (WE) obs_q.push_back('{Addr, Dout});
        if (WE && BE !== 4'hF) be_bad++;
        if (!WE && BE !== 4'h0) be_bad++;
    end

    // Decodes each byte on uart_txd and measures falling edge to done.
    initial begin : tx_mon
        ack_t a;
        int   t0;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && uart_txd === 1'b0) begin
                t0 = cyc;
                a.b = 8'h00;
                repeat (B / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (B) @(negedge clk);
                    a.b[i] = uart_txd;
                end
                repeat (B) @(negedge clk);
                a.stop = uart_txd;
                a.len = -1;
                for (int k = 0; k < B; k++) begin
                    @(negedge clk);
                    if (done) begin
                        a.len = cyc - t0;
                        break;
                    end
                end
                ack_q.push_back(a);
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        uart_rxd = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (B) @(negedge clk);
        end
        uart_rxd = stop_ok;
        repeat (B) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic build_frame(input logic [31:0] a, input int n, input logic [31:0] w0,
                               input logic [31:0] w1, input bit junk, output logic [7:0] q[$]);
        logic [15:0] n16;
        n16 = 16'(n);
        q = {};
        if (junk) begin
            q.push_back(8'h00);
            q.push_back(8'hFF);
        end
        q.push_back(8'hA5);
        for (int i = 0; i < 4; i++) q.push_back(a[8*i +: 8]);
        q.push_back(n16[7:0]);
        q.push_back(n16[15:8]);
        if (n > 0) for (int i = 0; i < 4; i++) q.push_back(w0[8*i +: 8]);
        if (n > 1) for (int i = 0; i < 4; i++) q.push_back(w1[8*i +: 8]);
    endtask

    task automatic wait_done(input int d0);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic check_writes();
        wr_t e, o;
        check("write_count", 32'(obs_q.size() - obs_rd), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            e = exp_q.pop_front();
            o = obs_q[obs_rd];
            obs_rd++;
            check("wr_addr", o.addr, e.addr);
            check("wr_data", o.data, e.data);
        end
        exp_q.delete();
        obs_rd = obs_q.size();
        check("byte_enables", 32'(be_bad), 32'd0);
    endtask

    task automatic check_ack();
        ack_t a;
        check("ack_count", 32'(ack_q.size() - ack_rd), 32'd1);
        if (ack_q.size() > ack_rd) begin
            a = ack_q[ack_rd];
            check("ack_byte", 32'(a.b), 32'h5A);
            check("ack_stop", 32'(a.stop), 32'd1);
            check("ack_length", 32'(a.len), 32'd160);
        end
        ack_rd = ack_q.size();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_txd"}, 32'(uart_txd), 32'd1);
        check({tag, "_we"}, 32'(WE), 32'd0);
        check({tag, "_be"}, 32'(BE), 32'd0);
        check({tag, "_addr"}, Addr, 32'd0);
        check({tag, "_dout"}, Dout, 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ferr"}, 32'(frame_err), 32'd0);
    endtask

    initial begin : main
        vec_t       vt[4];
        logic [7:0] fq[$];
        int         d0, f0, a0;

        vt[0] = '{32'h0000_1000, 2, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_1000, 32'h0000_1004, 1'b0};
        vt[1] = '{32'h0000_2003, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1};
        vt[2] = '{32'hFFFF_FFFC, 2, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
        vt[3] = '{32'h3000_0006, 1, 32'hCAFE_F00D, 32'h0, 32'h3000_0004, 32'h0, 1'b0};

        reset = 1'b1;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("por");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            if (vt[v].n > 0) exp_q.push_back('{vt[v].ea0, vt[v].w0});
            if (vt[v].n > 1) exp_q.push_back('{vt[v].ea1, vt[v].w1});
            build_frame(vt[v].addr, vt[v].n, vt[v].w0, vt[v].w1, vt[v].junk, fq);
            d0 = done_cnt;
            foreach (fq[i]) send_byte(fq[i], 1'b1);
            wait_done(d0);
            check_writes();
            check_ack();
        end

        // Bad stop bit in the middle of the address field.
        f0 = ferr_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h33, 1'b0);
        repeat (10) @(negedge clk);
        check("frame_err_pulse", 32'(ferr_cnt - f0), 32'd1);
        exp_q.push_back('{32'h0000_5000, 32'h0BAD_F00D});
        build_frame(32'h0000_5000, 1, 32'h0BAD_F00D, 32'h0, 1'b0, fq);
        d0 = done_cnt;
        foreach (fq[i]) send_byte(fq[i], 1'b1);
        wait_done(d0);
        check_writes();
        check_ack();

        // 4-cycle low glitch inserted after the first address byte.
        f0 = ferr_cnt;
        exp_q.push_back('{32'h0000_6000, 32'h7654_3210});
        build_frame(32'h0000_6000, 1, 32'h7654_3210, 32'h0, 1'b0, fq);
        d0 = done_cnt;
        foreach (fq[i]) begin
            send_byte(fq[i], 1'b1);
            if (i == 1) begin
                uart_rxd = 1'b0;
                repeat (4) @(negedge clk);
                uart_rxd = 1'b1;
                repeat (3 * B) @(negedge clk);
            end
        end
        wait_done(d0);
        check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        check_writes();
        check_ack();

        // Reset after the 5th data byte of an N=2 frame.
        exp_q.push_back('{32'h0000_4000, 32'hA1B2_C3D4});
        build_frame(32'h0000_4000, 2, 32'hA1B2_C3D4, 32'h0102_0304, 1'b0, fq);
        d0 = done_cnt;
        a0 = ack_q.size();
        for (int i = 0; i < 12; i++) send_byte(fq[i], 1'b1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("midrst");
        reset = 1'b0;
        check_writes();
        for (int i = 12; i < fq.size(); i++) send_byte(fq[i], 1'b1);
        repeat (400) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        check("midrst_no_ack", 32'(ack_q.size() - a0), 32'd0);
        check("midrst_txd_idle", 32'(uart_txd), 32'd1);
        check_writes();
        ack_rd = ack_q.size();

        exp_q.push_back('{vt[0].ea0, vt[0].w0});
        exp_q.push_back('{vt[0].ea1, vt[0].w1});
        build_frame(vt[0].addr, vt[0].n, vt[0].w0, vt[0].w1, 1'b0, fq);
        d0 = done_cnt;
        foreach (fq[i]) send_byte(fq[i], 1'b1);
        wait_done(d0);
        check_writes();
        check_ack();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
